// File: rtl/fifo_stream_reader.sv
// Read-side consumer for the synchronous FIFO: issues reads, absorbs the
// 1-cycle read latency in a 2-entry skid buffer and presents a valid/ready stream.
module fifo_stream_reader #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    output logic                  fifo_rd_en,
    input  logic [FIFO_WIDTH-1:0] fifo_data_out,
    input  logic                  fifo_empty,
    input  logic                  fifo_underflow,
    output logic                  m_valid,
    output logic [FIFO_WIDTH-1:0] m_data,
    input  logic                  m_ready,
    output logic [CNT_WIDTH-1:0]  rd_count,
    output logic                  err_underflow,
    input  logic                  clr_err
);

    logic [1:0]            occ;
    logic                  inflight;
    logic [FIFO_WIDTH-1:0] buf_head;
    logic [FIFO_WIDTH-1:0] buf_tail;
    logic                  pop;
    logic [2:0]            level;

    assign m_valid = (occ != 2'd0);
    assign m_data  = buf_head;
    assign pop     = m_valid && m_ready;

    // Occupancy after this cycle's pop, counting the word already in flight;
    // a new read is only issued if it is guaranteed a free slot.
    assign level      = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
    assign fifo_rd_en = rst_n && !fifo_empty && (level < 3'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ      <= 2'd0;
            inflight <= 1'b0;
            buf_head <= '0;
            buf_tail <= '0;
        end else begin
            inflight <= fifo_rd_en;
            case ({pop, inflight})
                2'b11: begin
                    if (occ == 2'd2) begin
                        buf_head <= buf_tail;
                        buf_tail <= fifo_data_out;
                    end else begin
                        buf_head <= fifo_data_out;
                    end
                end
                2'b10: begin
                    buf_head <= buf_tail;
                    occ      <= occ - 2'd1;
                end
                2'b01: begin
                    if (occ == 2'd0) begin
                        buf_head <= fifo_data_out;
                    end else begin
                        buf_tail <= fifo_data_out;
                    end
                    occ <= occ + 2'd1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count <= '0;
        end else if (pop) begin
            rd_count <= rd_count + 1'b1;
        end
    end

    // Set has priority over clear so a fault in the clearing cycle is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_underflow <= 1'b0;
        end else if (fifo_underflow) begin
            err_underflow <= 1'b1;
        end else if (clr_err) begin
            err_underflow <= 1'b0;
        end
    end

endmodule
